// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: aluop codes,
// bus/register constants, LSU state encoding and op classification helpers.
package mem_lsu_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic                  RstEnable  = 1'b1;
    localparam logic [RegBus-1:0]     ZeroWord   = 32'h0000_0000;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_BUS   = 2'd1,
        LSU_DONE  = 2'd2,
        LSU_DRAIN = 2'd3
    } lsu_state_t;

    function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_load_op(input logic [AluOpBus-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_mem_op(input logic [AluOpBus-1:0] op);
        return is_load_op(op) || is_store_op(op);
    endfunction

    function automatic logic is_misaligned(input logic [AluOpBus-1:0] op,
                                           input logic [1:0] lo);
        logic half, word;
        half = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
        word = (op == EXE_LW_OP) || (op == EXE_SW_OP);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Big-endian byte-lane logic: byte enables, store replication and load
// extract/extend for a given aluop and low address bits.
module lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'b00:   byte_v = rdata[31:24];
            2'b01:   byte_v = rdata[23:16];
            2'b10:   byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel       = 4'b0000;
        wdata     = reg2;
        load_data = ZeroWord;
        case (aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{reg2[7:0]}};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = {2{reg2[15:0]}};
            end
            EXE_LW_OP, EXE_SW_OP: sel = 4'b1111;
            default: ;
        endcase
        case (aluop)
            EXE_LB_OP:  load_data = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: load_data = {24'h000000, byte_v};
            EXE_LH_OP:  load_data = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: load_data = {16'h0000, half_v};
            EXE_LW_OP:  load_data = rdata;
            default:    load_data = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one req/ack data-bus transaction per
// aligned memory op, stalls the pipeline until done, passes other ops through.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        misalign,
    output logic [1:0]  dbg_state
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  lo_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [7:0]  op_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic        flushed_q;
    logic [31:0] result_q;

    logic        mem_op, mis, issue;
    logic [7:0]  lane_op;
    logic [1:0]  lane_lo;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata, lane_load;

    assign mem_op = is_mem_op(mem_aluop);
    assign mis    = is_misaligned(mem_aluop, mem_mem_addr[1:0]);
    assign issue  = (state_q == LSU_IDLE) && mem_op && !flush && !mis;

    // One lane instance: live op at issue time, registered op while on the bus.
    assign lane_op = (state_q == LSU_BUS) ? op_q : mem_aluop;
    assign lane_lo = (state_q == LSU_BUS) ? lo_q : mem_mem_addr[1:0];

    lsu_lane u_lane (
        .aluop     (lane_op),
        .addr_lo   (lane_lo),
        .reg2      (mem_reg2),
        .rdata     (dbus_rdata),
        .sel       (lane_sel),
        .wdata     (lane_wdata),
        .load_data (lane_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) state_q <= LSU_IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (issue) state_d = LSU_BUS;
            LSU_BUS: begin
                if (dbus_ack) state_d = (flushed_q || flush) ? LSU_DRAIN : LSU_DONE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            addr_q    <= ZeroWord;
            lo_q      <= 2'b00;
            sel_q     <= 4'b0000;
            we_q      <= 1'b0;
            wdata_q   <= ZeroWord;
            op_q      <= EXE_NOP_OP;
            wd_q      <= NOPRegAddr;
            wreg_q    <= 1'b0;
            flushed_q <= 1'b0;
            result_q  <= ZeroWord;
        end else if (issue) begin
            addr_q    <= {mem_mem_addr[31:2], 2'b00};
            lo_q      <= mem_mem_addr[1:0];
            sel_q     <= lane_sel;
            we_q      <= is_store_op(mem_aluop);
            wdata_q   <= lane_wdata;
            op_q      <= mem_aluop;
            wd_q      <= mem_wd;
            wreg_q    <= mem_wreg;
            flushed_q <= 1'b0;
        end else if (state_q == LSU_BUS) begin
            if (flush)    flushed_q <= 1'b1;
            if (dbus_ack) result_q  <= lane_load;
        end
    end

    // wb fields are forced to reset values while rst is held, even though
    // the pass-through path is otherwise purely combinational.
    always_comb begin
        stallreq = 1'b0;
        misalign = 1'b0;
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        if (rst == RstEnable) begin
            wb_wd    = NOPRegAddr;
            wb_wreg  = 1'b0;
            wb_wdata = ZeroWord;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (mem_op) begin
                        wb_wreg  = 1'b0;
                        misalign = mis && !flush;
                        stallreq = issue;
                    end
                end
                LSU_BUS: begin
                    stallreq = 1'b1;
                    wb_wd    = wd_q;
                    wb_wreg  = 1'b0;
                    wb_wdata = ZeroWord;
                end
                LSU_DONE: begin
                    wb_wd    = wd_q;
                    wb_wreg  = wreg_q && !we_q;
                    wb_wdata = result_q;
                end
                default: begin
                    wb_wd    = wd_q;
                    wb_wreg  = 1'b0;
                    wb_wdata = result_q;
                end
            endcase
        end
    end

    assign dbus_req   = (state_q == LSU_BUS);
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule
